// File: rtl/fdiv_issue_ctrl_pkg.sv
// Shared types and helpers for the FP divide issue/retire controller.
//   state_e     : controller FSM states
//   fp_class_t  : per-operand classification {is_zero,is_inf,is_nan,is_snan}
//   FF_*        : bit positions inside the RISC-V fflags vector {NV,DZ,OF,UF,NX}
//   CANON_NAN   : canonical quiet NaN returned for invalid operations
package fdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned FF_NV = 4;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_class_t;

  // Denormals are deliberately not flagged: they are ordinary divider work.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    fp_class_t c;
    c.is_zero = (x[30:23] == 8'h00) && (x[22:0] == 23'd0);
    c.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    c.is_snan = c.is_nan && !x[22];
    return c;
  endfunction

  // Flags reconstructed from the shape of the divider result.
  function automatic logic [4:0] div_result_flags(input logic [31:0] s);
    logic [4:0] f;
    f = 5'b00000;
    if ((s[30:23] == 8'hFF) && (s[22:0] == 23'd0)) begin
      f[FF_OF] = 1'b1;
      f[FF_NX] = 1'b1;
    end else if ((s[30:23] == 8'h00) && (s[22:0] != 23'd0)) begin
      f[FF_UF] = 1'b1;
      f[FF_NX] = 1'b1;
    end else begin
      f = 5'b00000;
    end
    return f;
  endfunction

endpackage

// File: rtl/fdiv_issue_ctrl_if.sv
// Request/response handshake bundle between a requester and fdiv_issue_ctrl.
//   req_* : divide request (valid/ready, operands, rounding mode, tag)
//   rsp_* : completion (valid/ready, result, fflags, tag, watchdog marker)
// master = requester side, slave = controller side.
interface fdiv_issue_ctrl_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_rm;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, req_rm, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rm, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout
  );
endinterface

// File: rtl/fdiv_issue_ctrl_special.sv
// Combinational special-operand resolver for single-precision division.
//   a, b       : operands
//   is_special : result is fully determined here, divider not needed
//   result     : special-case quotient (don't care when !is_special)
//   flags      : {NV,DZ,OF,UF,NX} for the special case
module fdiv_issue_ctrl_special
  import fdiv_issue_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  fp_class_t ca;
  fp_class_t cb;
  logic      sgn;

  assign ca  = fp_classify(a);
  assign cb  = fp_classify(b);
  assign sgn = a[31] ^ b[31];

  // Priority chain: NaN, invalid, divide-by-zero, infinite, zero quotient.
  always_comb begin
    is_special = 1'b1;
    result     = CANON_NAN;
    flags      = 5'b00000;
    if (ca.is_nan || cb.is_nan) begin
      flags[FF_NV] = ca.is_snan | cb.is_snan;
    end else if ((ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      flags[FF_NV] = 1'b1;
    end else if (cb.is_zero && !ca.is_inf) begin
      result       = {sgn, 8'hFF, 23'd0};
      flags[FF_DZ] = 1'b1;
    end else if (ca.is_inf) begin
      // Inf / 0 also lands here: infinite quotient, no DZ.
      result = {sgn, 8'hFF, 23'd0};
    end else if (ca.is_zero || cb.is_inf) begin
      result = {sgn, 8'h00, 23'd0};
    end else begin
      is_special = 1'b0;
      result     = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Issue/retire controller in front of the Newton-Raphson FP divider.
//   clk, clrn        : clock, async active-low reset (shared with the divider)
//   bus (slave)      : request/response handshake, see fdiv_issue_ctrl_if
//   div_a/b/rm       : divider operands, stable from ISSUE through WAIT
//   div_fdiv         : one-cycle start pulse (ISSUE)
//   div_ena          : divider enable (ISSUE and WAIT)
//   div_busy, div_s  : divider status and result (valid when busy falls)
// Special operands bypass the divider and respond one cycle after acceptance.
module fdiv_issue_ctrl
  import fdiv_issue_ctrl_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                clrn,
  fdiv_issue_ctrl_if.slave    bus,
  output logic [31:0]         div_a,
  output logic [31:0]         div_b,
  output logic [1:0]          div_rm,
  output logic                div_fdiv,
  output logic                div_ena,
  input  logic                div_busy,
  input  logic [31:0]         div_s
);

  localparam logic [4:0] WD_MAX = 5'(TIMEOUT);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       rm_q, rm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             seen_busy_q, seen_busy_d;
  logic [4:0]       wd_cnt_q, wd_cnt_d;
  logic [31:0]      result_q, result_d;
  logic [4:0]       flags_q, flags_d;
  logic             timeout_q, timeout_d;

  logic             sp_is_special;
  logic [31:0]      sp_result;
  logic [4:0]       sp_flags;
  logic             div_done_s;
  logic             wd_expired_s;

  fdiv_issue_ctrl_special u_special (
    .a          (bus.req_a),
    .b          (bus.req_b),
    .is_special (sp_is_special),
    .result     (sp_result),
    .flags      (sp_flags)
  );

  // Completion only counts after the divider has actually raised busy.
  assign div_done_s   = seen_busy_q && !div_busy;
  assign wd_expired_s = (wd_cnt_q == WD_MAX);

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.req_valid) state_d = sp_is_special ? DONE : ISSUE;
             else               state_d = IDLE;
      ISSUE: state_d = WAIT;
      WAIT:  if (div_done_s || wd_expired_s) state_d = DONE;
             else                            state_d = WAIT;
      DONE:  if (bus.rsp_ready) state_d = IDLE;
             else               state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and divider control decoded from the state register.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    div_fdiv      = 1'b0;
    div_ena       = 1'b0;
    case (state_q)
      IDLE:  bus.req_ready = 1'b1;
      ISSUE: begin
        div_fdiv = 1'b1;
        div_ena  = 1'b1;
      end
      WAIT:  div_ena = 1'b1;
      DONE:  bus.rsp_valid = 1'b1;
      default: bus.req_ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, watchdog, result selection.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    rm_d        = rm_q;
    tag_d       = tag_q;
    seen_busy_d = seen_busy_q;
    wd_cnt_d    = wd_cnt_q;
    result_d    = result_q;
    flags_d     = flags_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d       = bus.req_a;
          b_d       = bus.req_b;
          rm_d      = bus.req_rm;
          tag_d     = bus.req_tag;
          result_d  = sp_result;
          flags_d   = sp_flags;
          timeout_d = 1'b0;
        end else begin
          a_d = a_q;
        end
      end
      ISSUE: begin
        wd_cnt_d    = 5'd0;
        seen_busy_d = 1'b0;
      end
      WAIT: begin
        seen_busy_d = seen_busy_q | div_busy;
        wd_cnt_d    = wd_expired_s ? wd_cnt_q : (wd_cnt_q + 5'd1);
        if (div_done_s) begin
          result_d  = div_s;
          flags_d   = div_result_flags(div_s);
          timeout_d = 1'b0;
        end else if (wd_expired_s) begin
          result_d  = CANON_NAN;
          flags_d   = 5'b10000;
          timeout_d = 1'b1;
        end else begin
          result_d = result_q;
        end
      end
      DONE: result_d = result_q;
      default: result_d = result_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rm_q        <= 2'd0;
      tag_q       <= '0;
      seen_busy_q <= 1'b0;
      wd_cnt_q    <= 5'd0;
      result_q    <= 32'd0;
      flags_q     <= 5'd0;
      timeout_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      rm_q        <= rm_d;
      tag_q       <= tag_d;
      seen_busy_q <= seen_busy_d;
      wd_cnt_q    <= wd_cnt_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      timeout_q   <= timeout_d;
    end
  end

  assign div_a           = a_q;
  assign div_b           = b_q;
  assign div_rm          = rm_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_flags   = flags_q;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed self-checking bench for fdiv_issue_ctrl with a behavioural divider model.
module tb_fdiv_issue_ctrl;
  localparam int TIMEOUT = 31;

  logic        clk;
  logic        clrn;
  logic [31:0] div_a, div_b, div_s;
  logic [1:0]  div_rm;
  logic        div_fdiv, div_ena, div_busy;

  fdiv_issue_ctrl_if #(.TAG_W(4)) bus();

  fdiv_issue_ctrl #(.TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .bus(bus),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
    .div_fdiv(div_fdiv), .div_ena(div_ena),
    .div_busy(div_busy), .div_s(div_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model knobs, driven from the stimulus block.
  int          mdl_lat;
  logic [31:0] mdl_res;
  logic        mdl_stuck;
  int          mdl_cnt;
  int          fdiv_cnt;
  int          ena_cnt;

  // Behavioural divider: busy for mdl_lat cycles after the start pulse.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_busy <= 1'b0;
      div_s    <= 32'd0;
      mdl_cnt  <= 0;
    end else if (div_fdiv) begin
      div_busy <= 1'b1;
      mdl_cnt  <= mdl_lat;
    end else if (div_busy && !mdl_stuck) begin
      if (mdl_cnt <= 1) begin
        div_busy <= 1'b0;
        div_s    <= mdl_res;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // Start-pulse and enable activity counters.
  initial begin
    fdiv_cnt = 0;
    ena_cnt  = 0;
  end
  always @(posedge clk) begin
    if (div_fdiv) fdiv_cnt <= fdiv_cnt + 1;
    if (div_ena)  ena_cnt  <= ena_cnt + 1;
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm, input logic [3:0] tag);
    @(negedge clk);
    chk("req_ready_before_send", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rm    = rm;
    bus.req_tag   = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!bus.rsp_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) chk("rsp_wait_bound", 32'd0, 32'd1);
  endtask

  // Special operand vectors: a, b, expected result, expected flags.
  localparam int NSP = 10;
  localparam logic [31:0] SP_A [NSP] = '{32'h4AC86898, 32'h00000000, 32'h00000000, 32'h7F800001,
    32'h7FC00001, 32'h7F800000, 32'hFF800000, 32'h40000000, 32'hC0000000, 32'h7F800000};
  localparam logic [31:0] SP_B [NSP] = '{32'h00000000, 32'hCB078682, 32'h00000000, 32'h3F800000,
    32'h3F800000, 32'hFF800000, 32'h40000000, 32'h7F800000, 32'h80000000, 32'h00000000};
  localparam logic [31:0] SP_R [NSP] = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h7FC00000,
    32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h7F800000, 32'h7F800000};
  localparam logic [4:0]  SP_F [NSP] = '{5'b01000, 5'b00000, 5'b10000, 5'b10000,
    5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b00000};

  // Normal-path vectors: a, b, divider latency, divider result, expected flags.
  localparam int NNP = 4;
  localparam logic [31:0] NP_A [NNP] = '{32'h41000000, 32'h3F800000, 32'h3F800000, 32'h00000001};
  localparam logic [31:0] NP_B [NNP] = '{32'h40800000, 32'h40000000, 32'h40000000, 32'h3F800000};
  localparam int          NP_L [NNP] = '{3, 4, 2, 3};
  localparam logic [31:0] NP_S [NNP] = '{32'h40000000, 32'h7F800000, 32'h00000001, 32'h00000001};
  localparam logic [4:0]  NP_F [NNP] = '{5'b00000, 5'b00101, 5'b00011, 5'b00011};

  initial begin
    int n;
    int base_f;
    int base_e;
    int seen;
    total = 0;
    bad   = 0;
    clrn  = 1'b0;
    mdl_lat = 3;
    mdl_res = 32'd0;
    mdl_stuck = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = 32'd0;
    bus.req_b = 32'd0;
    bus.req_rm = 2'd0;
    bus.req_tag = 4'd0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_div_ena", {31'd0, div_ena}, 32'd0);
    chk("rst_div_fdiv", {31'd0, div_fdiv}, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    clrn = 1'b1;

    // Normal divides through the model.
    for (int i = 0; i < NNP; i++) begin
      mdl_lat = NP_L[i];
      mdl_res = NP_S[i];
      base_f  = fdiv_cnt;
      send(NP_A[i], NP_B[i], 2'b01, 4'(i + 1));
      @(negedge clk);
      chk("np_fdiv", {31'd0, div_fdiv}, 32'd1);
      chk("np_div_a", div_a, NP_A[i]);
      chk("np_div_b", div_b, NP_B[i]);
      chk("np_div_rm", {30'd0, div_rm}, 32'd1);
      chk("np_req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
      wait_rsp(60, n);
      chk("np_result", bus.rsp_result, NP_S[i]);
      chk("np_flags", {27'd0, bus.rsp_flags}, {27'd0, NP_F[i]});
      chk("np_tag", {28'd0, bus.rsp_tag}, 32'(i + 1));
      chk("np_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
      chk("np_fdiv_once", 32'(fdiv_cnt - base_f), 32'd1);
      ack();
      chk("np_idle_after_ack", {31'd0, bus.req_ready}, 32'd1);
    end

    // Special operands: one cycle to response, divider untouched.
    base_e = ena_cnt;
    for (int i = 0; i < NSP; i++) begin
      send(SP_A[i], SP_B[i], 2'b00, 4'(i));
      @(negedge clk);
      chk("sp_valid_1cyc", {31'd0, bus.rsp_valid}, 32'd1);
      chk("sp_result", bus.rsp_result, SP_R[i]);
      chk("sp_flags", {27'd0, bus.rsp_flags}, {27'd0, SP_F[i]});
      ack();
    end
    chk("sp_no_div_ena", 32'(ena_cnt - base_e), 32'd0);

    // Backpressure: response held for 5 cycles with rsp_ready low.
    mdl_lat = 3;
    mdl_res = 32'h3F000000;
    send(32'h3F800000, 32'h40000000, 2'b00, 4'd5);
    wait_rsp(60, n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_result", bus.rsp_result, 32'h3F000000);
      chk("bp_tag", {28'd0, bus.rsp_tag}, 32'd5);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    ack();
    send(32'h00000000, 32'h00000000, 2'b00, 4'd7);
    @(negedge clk);
    chk("bp_next_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_next_tag", {28'd0, bus.rsp_tag}, 32'd7);
    ack();

    // Stuck divider: watchdog abort.
    mdl_stuck = 1'b1;
    send(32'h40400000, 32'h40000000, 2'b00, 4'd9);
    wait_rsp(100, n);
    chk("wd_latency_in_range", {31'd0, (n >= TIMEOUT) && (n <= TIMEOUT + 4)}, 32'd1);
    chk("wd_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
    chk("wd_result", bus.rsp_result, 32'h7FC00000);
    chk("wd_flags", {27'd0, bus.rsp_flags}, 32'h10);
    chk("wd_tag", {28'd0, bus.rsp_tag}, 32'd9);
    ack();
    mdl_stuck = 1'b0;

    // Watchdog must restart on ISSUE: a long but finite divide completes.
    mdl_lat = 25;
    mdl_res = 32'h3F800000;
    send(32'h3F800000, 32'h3F800000, 2'b00, 4'd10);
    wait_rsp(100, n);
    chk("wdclr_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    chk("wdclr_result", bus.rsp_result, 32'h3F800000);
    ack();

    // Reset mid-WAIT aborts the operation.
    mdl_stuck = 1'b1;
    send(32'h40A00000, 32'h40000000, 2'b00, 4'd12);
    repeat (5) @(negedge clk);
    chk("rw_in_wait", {31'd0, div_ena}, 32'd1);
    clrn = 1'b0;
    #1;
    chk("rw_div_ena", {31'd0, div_ena}, 32'd0);
    chk("rw_div_a", div_a, 32'd0);
    chk("rw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rw_rsp_tag", {28'd0, bus.rsp_tag}, 32'd0);
    mdl_stuck = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("rw_no_response", 32'(seen), 32'd0);
    chk("rw_req_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
